// File: rtl/neuron_accum_reg_pkg.sv
// Shared types and helpers for the neuron membrane-potential register.
package neuron_pkg;

  localparam int NEURON_W = 8;

  typedef enum logic [1:0] {INTEG, FIRE, REFRACT} neuron_state_t;

  // A carry out of the adder means the true sum overflowed, so clamp to full scale.
  function automatic logic [NEURON_W-1:0] sat_sum(input logic [NEURON_W-1:0] sum,
                                                  input logic                cout);
    return cout ? '1 : sum;
  endfunction

endpackage

// File: rtl/neuron_accum_reg_if.sv
// Adder-result handshake between the ripple adder (master) and the neuron register (slave).
interface neuron_accum_reg_if import neuron_pkg::*; #(
  parameter int WIDTH = NEURON_W
) ();

  logic             sum_vld;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             sum_rdy;

  modport master (output sum_vld, sum, cout, input sum_rdy);
  modport slave  (input sum_vld, sum, cout, output sum_rdy);

endinterface

// File: rtl/neuron_accum_reg_refract_timer.sv
// Loadable down-counter timing the refractory window; done flags the last cycle.
module refract_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/neuron_accum_reg.sv
// Integrate-and-fire membrane register with saturation, one-cycle spike and refractory window.
// Optional leak enabled by defining NEURON_LEAK_EN.
module neuron_accum_reg import neuron_pkg::*; #(
  parameter int WIDTH       = NEURON_W,
  parameter int THRESH      = 200,
  parameter int V_RESET     = 0,
  parameter int REFRACT_CYC = 4,
  parameter int LEAK_SHIFT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  neuron_accum_reg_if.slave  bus,
  input  logic               leak_tick,
  output logic [WIDTH-1:0]   vmem,
  output logic               spike,
  output logic               refract,
  output logic [7:0]         spike_cnt
);

  if (THRESH > (1 << WIDTH) - 1) begin : g_bad_thresh
    $error("neuron_accum_reg: THRESH %0d exceeds %0d-bit range", THRESH, WIDTH);
  end
  if (WIDTH != NEURON_W) begin : g_bad_width
    $error("neuron_accum_reg: WIDTH %0d must match adder width %0d", WIDTH, NEURON_W);
  end

  localparam logic [WIDTH-1:0] TH_V  = THRESH[WIDTH-1:0];
  localparam logic [WIDTH-1:0] VRST  = V_RESET[WIDTH-1:0];
  localparam logic [7:0]       RC_V  = REFRACT_CYC[7:0];

  neuron_state_t    state, state_d;
  logic [WIDTH-1:0] vmem_d, nxt;
  logic             spike_d, fire_done, xfer, rdone;
  logic [7:0]       rcnt;

  logic unused_leak;
  assign unused_leak = leak_tick ^ LEAK_SHIFT[0];

  assign bus.sum_rdy = (state == INTEG) && !rst;
  assign xfer        = bus.sum_vld && bus.sum_rdy;
  assign nxt         = sat_sum(bus.sum, bus.cout);
  assign refract     = (state == REFRACT);

  always_comb begin
    state_d   = state;
    vmem_d    = vmem;
    spike_d   = 1'b0;
    fire_done = 1'b0;
    case (state)
      INTEG: begin
        if (xfer) begin
          vmem_d = nxt;
          if (nxt >= TH_V) begin
            state_d = FIRE;
            spike_d = 1'b1;
          end
        end
`ifdef NEURON_LEAK_EN
        // Leak only when no transfer arrives; it can only lower vmem, so it never fires.
        else if (leak_tick) begin
          vmem_d = vmem - (vmem >> LEAK_SHIFT);
        end
`endif
      end
      FIRE: begin
        vmem_d    = VRST;
        fire_done = 1'b1;
        state_d   = (REFRACT_CYC == 0) ? INTEG : REFRACT;
      end
      REFRACT: begin
        if (rdone) state_d = INTEG;
      end
      default: state_d = INTEG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INTEG;
      vmem      <= VRST;
      spike     <= 1'b0;
      spike_cnt <= '0;
    end else begin
      state <= state_d;
      vmem  <= vmem_d;
      spike <= spike_d;
      if (fire_done) spike_cnt <= spike_cnt + 8'd1;
    end
  end

  refract_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (fire_done),
    .load_val (RC_V),
    .en       (refract),
    .cnt      (rcnt),
    .done     (rdone)
  );

endmodule

// File: tb/tb_neuron_accum_reg.sv
// Scoreboard bench for neuron_accum_reg: expected vmem/spike queued per transfer.
module tb_neuron_accum_reg;
  import neuron_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       leak_tick = 1'b0;
  logic [7:0] vmem;
  logic       spike, refract;
  logic [7:0] spike_cnt;

  neuron_accum_reg_if #(.WIDTH(8)) bus ();

  neuron_accum_reg #(
    .WIDTH(8), .THRESH(200), .V_RESET(0), .REFRACT_CYC(4), .LEAK_SHIFT(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .leak_tick (leak_tick),
    .vmem      (vmem),
    .spike     (spike),
    .refract   (refract),
    .spike_cnt (spike_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vmem;
    logic       spike;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.sum_rdy && n < 20) begin
      tick();
      n++;
    end
    if (!bus.sum_rdy) chk({tag, "_rdy_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk({tag, "_vmem"}, vmem, e.vmem);
    chk({tag, "_spike"}, spike, e.spike);
  endtask

  task automatic send(input string tag, input logic [7:0] s, input logic c,
                      input logic [7:0] ev, input logic es);
    exp_t e;
    wait_ready(tag);
    bus.sum_vld = 1'b1;
    bus.sum     = s;
    bus.cout    = c;
    e.vmem = ev;
    e.spike = es;
    q.push_back(e);
    tick();
    bus.sum_vld = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    int lowc, refc, spkc, n, k;
    exp_t e;
    bus.sum_vld = 1'b0;
    bus.sum     = '0;
    bus.cout    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_vmem", vmem, 0);
    chk("rst_spike", spike, 0);
    chk("rst_refract", refract, 0);
    chk("rst_cnt", spike_cnt, 0);
    chk("rst_rdy_low", bus.sum_rdy, 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy_high", bus.sum_rdy, 1);

    // 1: plain integrate
    send("t1", 8'd50, 1'b0, 8'd50, 1'b0);
    chk("t1_rdy", bus.sum_rdy, 1);

    // 2: exactly THRESH fires; refractory timing
    send("t2", 8'd200, 1'b0, 8'd200, 1'b1);
    chk("t2_rdy_fire", bus.sum_rdy, 0);
    lowc = 1; refc = 0; spkc = 1; n = 0;
    tick();
    chk("t2_vmem_reset", vmem, 0);
    chk("t2_refract", refract, 1);
    chk("t2_spike_off", spike, 0);
    chk("t2_cnt", spike_cnt, 1);
    while (!bus.sum_rdy && n < 20) begin
      if (refract) refc++;
      if (spike) spkc++;
      lowc++;
      tick();
      n++;
    end
    chk("t2_rdy_timeout", (n < 20), 1);
    chk("t2_rdy_low_cycles", lowc, 5);
    chk("t2_refract_cycles", refc, 4);
    chk("t2_spike_cycles", spkc, 1);

    // 3: carry saturates to 0xFF; held valid waits out the refractory window
    send("t3", 8'h10, 1'b1, 8'hFF, 1'b1);
    bus.sum_vld = 1'b1;
    bus.sum     = 8'd77;
    bus.cout    = 1'b0;
    k = 0;
    while (!bus.sum_rdy && k < 20) begin
      tick();
      k++;
      if (!bus.sum_rdy) chk("t3_held_not_taken", vmem, 0);
    end
    chk("t3_wait_cycles", k, 5);
    e.vmem = 8'd77;
    e.spike = 1'b0;
    q.push_back(e);
    tick();
    bus.sum_vld = 1'b0;
    pop_check("t3_held");
    chk("t3_cnt", spike_cnt, 2);

    // 4: reset during the second refractory cycle
    send("t4", 8'd210, 1'b0, 8'd210, 1'b1);
    tick();
    tick();
    chk("t4_refract2", refract, 1);
    chk("t4_cnt_pre", spike_cnt, 3);
    rst = 1'b1;
    tick();
    chk("t4_refract", refract, 0);
    chk("t4_vmem", vmem, 0);
    chk("t4_cnt", spike_cnt, 0);
    chk("t4_rdy_in_rst", bus.sum_rdy, 0);
    rst = 1'b0;
    #1;
    chk("t4_rdy_after", bus.sum_rdy, 1);

    // 5: leak, and a tick colliding with a transfer
    send("t5_load", 8'd160, 1'b0, 8'd160, 1'b0);
    leak_tick = 1'b1;
    tick();
    leak_tick = 1'b0;
`ifdef NEURON_LEAK_EN
    chk("t5_leak", vmem, 140);
`else
    chk("t5_noleak", vmem, 160);
`endif
    leak_tick = 1'b1;
    send("t5_coinc", 8'd30, 1'b0, 8'd30, 1'b0);
    leak_tick = 1'b0;
    send("t5_below", 8'd199, 1'b0, 8'd199, 1'b0);
    chk("t5_rdy_below", bus.sum_rdy, 1);

    // 6: spike counter wrap; THRESH-1 never fires
    chk("t6_cnt_start", spike_cnt, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(200 + (i % 56));
      send("t6_below", 8'd199, 1'b0, 8'd199, 1'b0);
      send("t6_fire", v, 1'b0, v, 1'b1);
      wait_ready("t6");
      if (i == 254) chk("t6_cnt_255", spike_cnt, 255);
    end
    chk("t6_cnt_wrap", spike_cnt, 0);
    chk("t6_sb_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
